// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, queue depth and the {pc, inst} entry type for the fetch buffer.
package fetch_pkg;
  localparam int FETCH_INST_SIZE = 32;
  localparam int FETCH_PC_SIZE = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;
  typedef struct packed {
    logic [FETCH_PC_SIZE-1:0] pc;
    logic [FETCH_INST_SIZE-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x W register array, one synchronous write port, one combinational read port, no reset.
//   clk          write clock
//   we/waddr/wdata  write enable, address, data
//   raddr/rdata  asynchronous read address and data
module fetch_queue_mem #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order first-word-fall-through buffer of {pc, inst} pairs between IF and ID, with flush.
//   clk, rst       clock; asynchronous active-low reset
//   in_valid/in_ready/in_pc/in_inst     producer handshake (in_ready = !full)
//   flush          discards every entry and the current offer
//   out_valid/out_ready/out_pc/out_inst consumer handshake; out data zero when empty
//   count/full/empty                    occupancy status
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int INST_SIZE = FETCH_INST_SIZE,
  parameter int PC_SIZE = FETCH_PC_SIZE,
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_SIZE-1:0]   in_pc,
  input  logic [INST_SIZE-1:0] in_inst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_SIZE-1:0]   out_pc,
  output logic [INST_SIZE-1:0] out_inst,
  output logic [PTR_W:0]       count,
  output logic                 full,
  output logic                 empty
);
  localparam int W = PC_SIZE + INST_SIZE;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] head;
  logic push, pop;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign out_pc = empty ? '0 : head[W-1:INST_SIZE];
  assign out_inst = empty ? '0 : head[INST_SIZE-1:0];
  fetch_queue_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata({in_pc, in_inst}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue.
module tb_fetch_queue;
  import fetch_pkg::*;
  logic clk = 0, rst = 0;
  logic in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = '0, in_inst = '0;
  logic in_ready, out_valid, full, empty;
  logic [31:0] out_pc, out_inst;
  logic [2:0] count;
  int vectors = 0, errs = 0;
  fetch_entry_t exp_q [$];

  fetch_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n = exp_q.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == 4));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("in_ready", 64'(in_ready), 64'(n != 4));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("out_pc", 64'(out_pc), n != 0 ? 64'(exp_q[0].pc) : 64'd0);
    chk("out_inst", 64'(out_inst), n != 0 ? 64'(exp_q[0].inst) : 64'd0);
  endtask

  // One clock at negedge: drive, check pre-edge state, advance model across the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    fetch_entry_t e;
    logic mpush, mpop;
    in_valid = v;
    in_pc = pc;
    in_inst = 32'h1300_0000 ^ {pc[15:0], ~pc[15:0]};
    out_ready = ordy;
    flush = fl;
    check_state();
    mpush = v && exp_q.size() < 4 && !fl;
    mpop = exp_q.size() > 0 && ordy && !fl;
    e.pc = in_pc;
    e.inst = in_inst;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (mpop) void'(exp_q.pop_front());
      if (mpush) exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0);
    cyc(1, 32'h10, 0, 0);
    cyc(1, 32'h10, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h00, 0, 0);
    cyc(1, 32'h04, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'(8 + i * 4), 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h50, 0, 0);
    cyc(1, 32'h54, 0, 0);
    cyc(1, 32'h58, 0, 0);
    cyc(1, 32'h40, 1, 1);
    cyc(1, 32'h80, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 32'hA0, 0, 0);
    cyc(1, 32'hA4, 0, 0);
    cyc(1, 32'hA8, 0, 0);
    in_valid = 0;
    check_state();
    #2 rst = 0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_pc", 64'(out_pc), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1;
    cyc(0, 0, 0, 0);
    cyc(1, 32'hC0, 0, 0);
    cyc(0, 0, 1, 0);
    check_state();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer-side fetch buffer that sits between the IF stage (PC + instruction producer) and the ID stage.
- Accepts fetched {PC, instruction} pairs through a valid/ready handshake and stores them in order in a DEPTH-entry FIFO.
- Presents the oldest pair to ID as first-word fall-through.
- Flush discards all buffered fetches on a taken branch so wrong-path instructions never reach ID.

Parameters:
- INST_SIZE, 32, instruction width in bits.
- PC_SIZE, 32, PC width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  IF offers a fetched pair.
- in_ready  output  1  queue can accept; equals !full.
- in_pc  input  PC_SIZE  PC of the offered instruction.
- in_inst  input  INST_SIZE  offered instruction word.
- flush  input  1  discard all entries (branch taken).
- out_valid  output  1  queue holds at least one entry; equals !empty.
- out_ready  input  1  ID consumes the head entry.
- out_pc  output  PC_SIZE  head entry PC; 0 when empty.
- out_inst  output  INST_SIZE  head entry instruction; 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs: full = 0, empty = 1, in_ready = 1, out_valid = 0, out_pc = 0, out_inst = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Push = in_valid & in_ready & !flush. On push, the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Pop = out_valid & out_ready & !flush. On pop, rd_ptr increments, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- in_ready depends only on registered state (!full). It has no combinational path from out_ready. While full, a push is refused even if a pop happens in the same cycle.
- out_valid, out_pc and out_inst depend only on registered state, with no combinational path from in_*.
  - An entry pushed in cycle N is visible at the output in cycle N+1, so write-to-read latency is 1 cycle.
  - out_pc and out_inst are masked to 0 when empty.
- Flush has priority over push and pop. On the edge it is sampled:
  - wr_ptr = rd_ptr = 0, count = 0.
  - The offered input and the head entry are both discarded.
  - The next cycle shows empty = 1 and in_ready = 1.
- Pop while empty is impossible because out_valid = 0.
- Push while full is impossible because in_ready = 0.
- Holding in_valid while in_ready = 0 leaves the input stalled. The producer holds in_pc and in_inst stable until accepted.
- With DEPTH = 4, PTR_W = 2, so count is 3 bits. Pointers wrap 3 -> 0. full and empty are derived from count, not from pointer comparison.

Decomposition:
- Shared package fetch_pkg:
  - INST_SIZE and PC_SIZE defaults.
  - The fetch_entry_t struct {pc, inst}.
  - The FETCH_QUEUE_DEPTH constant.
- One sub-module, fetch_queue_mem: DEPTH x (PC_SIZE + INST_SIZE) register array with one synchronous write port and one combinational read port. It has no reset.
- Pointer, count and flush control stay in fetch_queue.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high -> empty = 1, in_ready = 1, out_valid = 0, out_pc = 0, count = 0.
- Fill to full: push PCs 0x00, 0x04, 0x08, 0x0C with out_ready = 0 -> count goes 1, 2, 3, 4; full = 1 and in_ready = 0 after the 4th; a 5th offer of PC 0x10 is held, not stored.
- Drain in order: from full, out_ready = 1 for 4 cycles -> out_pc = 0x00, 0x04, 0x08, 0x0C on successive cycles, then empty = 1 and out_pc = 0.
- Simultaneous push/pop with wrap: keep count = 2 while pushing and popping continuously for 10 cycles (PCs 0x00..0x24) -> count stays 2, output order matches input order across the pointer wrap 3 -> 0.
- Flush priority: with 3 entries, assert flush together with in_valid (PC 0x40) and out_ready -> next cycle count = 0, empty = 1; 0x40 is never output; the next push (PC 0x80) appears at out_pc one cycle later.
- Async reset mid-stream: with count = 3, drop rst between clock edges -> count = 0 and out_valid = 0 immediately, before the next edge.
